// File: rtl/pc_unit.sv
// Program-counter stage: next-address select, return-address stack,
// halt/resume state machine and context-switch PC save register.
//
// Ports:
//   Clk, Reset          rising-edge clock, async active-high reset
//   Stall               freeze every register this cycle
//   Jump_R .. Change_Context, Branch_Cond
//                       decoder flow-control inputs
//   Imm_Addr, Reg_Addr, Ctx_Addr
//                       jump/branch/context targets
//   Resume              leave HALTED
//   PC                  current instruction address
//   Ctx_Saved_PC        PC+1 captured at last context switch
//   Halted              state machine is HALTED
//   Stack_Count         occupied return-stack entries
//   Stack_Overflow/Underflow  sticky stack error flags
module pc_unit #(
   parameter int unsigned           ADDR_WIDTH  = 10,
   parameter int unsigned           STACK_DEPTH = 16,
   parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0
) (
   input  logic                           Clk,
   input  logic                           Reset,
   input  logic                           Stall,
   input  logic                           Jump_R,
   input  logic                           Jump_I,
   input  logic                           Branch,
   input  logic                           Stack_Enable,
   input  logic                           Stack_Write,
   input  logic                           Halt,
   input  logic                           Change_Context,
   input  logic                           Branch_Cond,
   input  logic [ADDR_WIDTH-1:0]          Imm_Addr,
   input  logic [ADDR_WIDTH-1:0]          Reg_Addr,
   input  logic [ADDR_WIDTH-1:0]          Ctx_Addr,
   input  logic                           Resume,
   output logic [ADDR_WIDTH-1:0]          PC,
   output logic [ADDR_WIDTH-1:0]          Ctx_Saved_PC,
   output logic                           Halted,
   output logic [$clog2(STACK_DEPTH):0]   Stack_Count,
   output logic                           Stack_Overflow,
   output logic                           Stack_Underflow
);

   localparam int unsigned IW = $clog2(STACK_DEPTH);
   localparam int unsigned CW = IW + 1;

   localparam logic [ADDR_WIDTH-1:0] PC_ONE = ADDR_WIDTH'(1);
   localparam logic [IW-1:0]         IX_ONE = IW'(1);
   localparam logic [CW-1:0]         CT_ONE = CW'(1);
   localparam logic [CW-1:0]         CT_FULL = CW'(STACK_DEPTH);

   typedef enum logic {
      S_RUN,
      S_HALTED
   } state_e;

   state_e                  state_q, state_d;
   logic [ADDR_WIDTH-1:0]   pc_q, pc_d;
   logic [ADDR_WIDTH-1:0]   ctx_q, ctx_d;
   logic [CW-1:0]           cnt_q, cnt_d;
   logic                    ovf_q, ovf_d;
   logic                    unf_q, unf_d;
   logic [ADDR_WIDTH-1:0]   stack_q [STACK_DEPTH];

   logic [ADDR_WIDTH-1:0]   pc_inc;
   logic [IW-1:0]           wr_idx;
   logic [IW-1:0]           top_idx;
   logic                    st_empty;
   logic                    st_full;
   logic                    push_en;

   // Wraps naturally at 2^ADDR_WIDTH.
   assign pc_inc   = pc_q + PC_ONE;
   // The low bits of the count address the next free slot; when the
   // count is DEPTH they wrap to 0, so top_idx still lands on DEPTH-1.
   assign wr_idx   = cnt_q[IW-1:0];
   assign top_idx  = cnt_q[IW-1:0] - IX_ONE;
   assign st_empty = (cnt_q == '0);
   assign st_full  = (cnt_q == CT_FULL);

   // State register
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state_q <= S_RUN;
         pc_q    <= RESET_PC;
         ctx_q   <= '0;
         cnt_q   <= '0;
         ovf_q   <= 1'b0;
         unf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         ctx_q   <= ctx_d;
         cnt_q   <= cnt_d;
         ovf_q   <= ovf_d;
         unf_q   <= unf_d;
      end
   end

   // Stack storage needs no reset: entries above the count are unused.
   always_ff @(posedge Clk) begin
      if (push_en) begin
         stack_q[wr_idx] <= pc_inc;
      end
   end

   // Next-state and next-PC selection
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      ctx_d   = ctx_q;
      cnt_d   = cnt_q;
      ovf_d   = ovf_q;
      unf_d   = unf_q;
      push_en = 1'b0;
      if (!Stall) begin
         unique case (state_q)
            S_RUN: begin
               if (Halt) begin
                  state_d = S_HALTED;
               end else if (Change_Context) begin
                  pc_d  = Ctx_Addr;
                  ctx_d = pc_inc;
               end else if (Stack_Enable && !Stack_Write) begin
                  if (st_empty) begin
                     pc_d  = pc_inc;
                     unf_d = 1'b1;
                  end else begin
                     pc_d  = stack_q[top_idx];
                     cnt_d = cnt_q - CT_ONE;
                  end
               end else if (Stack_Enable) begin
                  pc_d = Imm_Addr;
                  if (st_full) begin
                     ovf_d = 1'b1;
                  end else begin
                     push_en = 1'b1;
                     cnt_d   = cnt_q + CT_ONE;
                  end
               end else if (Jump_R) begin
                  pc_d = Reg_Addr;
               end else if (Jump_I) begin
                  pc_d = Imm_Addr;
               end else if (Branch && Branch_Cond) begin
                  pc_d = Imm_Addr;
               end else begin
                  pc_d = pc_inc;
               end
            end
            S_HALTED: begin
               // Resume skips past the HALT instruction.
               if (Resume) begin
                  state_d = S_RUN;
                  pc_d    = pc_inc;
               end
            end
            default: begin
               state_d = S_RUN;
            end
         endcase
      end
   end

   // Outputs
   always_comb begin
      PC              = pc_q;
      Ctx_Saved_PC    = ctx_q;
      Halted          = (state_q == S_HALTED);
      Stack_Count     = cnt_q;
      Stack_Overflow  = ovf_q;
      Stack_Underflow = unf_q;
   end

endmodule

// File: tb/tb_pc_unit.sv
// Self-checking bench for pc_unit: scoreboard of expected
// architectural state, one task per scenario.
module tb_pc_unit;

   logic       Clk;
   logic       Reset;
   logic       Stall;
   logic       Jump_R, Jump_I, Branch;
   logic       Stack_Enable, Stack_Write;
   logic       Halt, Change_Context, Branch_Cond;
   logic [9:0] Imm_Addr, Reg_Addr, Ctx_Addr;
   logic       Resume;
   logic [9:0] PC, Ctx_Saved_PC;
   logic       Halted;
   logic [4:0] Stack_Count;
   logic       Stack_Overflow, Stack_Underflow;

   typedef struct packed {
      logic [9:0] pc;
      logic [9:0] ctx;
      logic [4:0] cnt;
      logic       ovf;
      logic       unf;
      logic       hlt;
   } exp_t;

   exp_t e;
   exp_t got;
   exp_t want;
   exp_t sb [$];
   int   total;
   int   bad;

   pc_unit #(
      .ADDR_WIDTH  (10),
      .STACK_DEPTH (16),
      .RESET_PC    (10'd0)
   ) dut (
      .Clk             (Clk),
      .Reset           (Reset),
      .Stall           (Stall),
      .Jump_R          (Jump_R),
      .Jump_I          (Jump_I),
      .Branch          (Branch),
      .Stack_Enable    (Stack_Enable),
      .Stack_Write     (Stack_Write),
      .Halt            (Halt),
      .Change_Context  (Change_Context),
      .Branch_Cond     (Branch_Cond),
      .Imm_Addr        (Imm_Addr),
      .Reg_Addr        (Reg_Addr),
      .Ctx_Addr        (Ctx_Addr),
      .Resume          (Resume),
      .PC              (PC),
      .Ctx_Saved_PC    (Ctx_Saved_PC),
      .Halted          (Halted),
      .Stack_Count     (Stack_Count),
      .Stack_Overflow  (Stack_Overflow),
      .Stack_Underflow (Stack_Underflow)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   function automatic exp_t obs();
      exp_t o;
      o = {PC, Ctx_Saved_PC, Stack_Count,
           Stack_Overflow, Stack_Underflow, Halted};
      return o;
   endfunction

   task automatic clr();
      Stall = 0; Jump_R = 0; Jump_I = 0; Branch = 0;
      Stack_Enable = 0; Stack_Write = 0; Halt = 0;
      Change_Context = 0; Branch_Cond = 0; Resume = 0;
      Imm_Addr = '0; Reg_Addr = '0; Ctx_Addr = '0;
   endtask

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   task automatic test_reset();
      clr();
      Reset = 1;
      repeat (2) @(posedge Clk);
      #1;
      Reset = 0;
      e = '0;
      sb.push_back(e);
      got = obs();
      want = sb.pop_front();
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL reset: got pc=%0d cnt=%0d ctx=%0d o/u/h=%b%b%b want pc=%0d cnt=%0d ctx=%0d o/u/h=%b%b%b",
                  got.pc, got.cnt, got.ctx, got.ovf, got.unf, got.hlt,
                  want.pc, want.cnt, want.ctx, want.ovf, want.unf, want.hlt);
      end
   endtask

   task automatic test_increment();
      for (int i = 1; i <= 6; i++) begin
         clr();
         if (i == 5) begin
            Jump_I = 1; Imm_Addr = 10'd1023;
            e.pc = 10'd1023;
         end else if (i == 6) begin
            e.pc = 10'd0;
         end else begin
            e.pc = 10'(i);
         end
         sb.push_back(e);
         tick();
         got = obs();
         want = sb.pop_front();
         total++;
         if (got !== want) begin
            bad++;
            $display("FAIL increment[%0d]: got pc=%0d cnt=%0d ctx=%0d o/u/h=%b%b%b want pc=%0d cnt=%0d ctx=%0d o/u/h=%b%b%b",
                     i, got.pc, got.cnt, got.ctx, got.ovf, got.unf, got.hlt,
                     want.pc, want.cnt, want.ctx, want.ovf, want.unf, want.hlt);
         end
      end
      clr();
   endtask

   task automatic test_jal_ret();
      for (int i = 0; i < 3; i++) begin
         clr();
         case (i)
            0: begin Jump_I = 1; Imm_Addr = 10'd5; e.pc = 10'd5; end
            1: begin
               Stack_Enable = 1; Stack_Write = 1; Imm_Addr = 10'd40;
               e.pc = 10'd40; e.cnt = 5'd1;
            end
            default: begin
               Stack_Enable = 1; Imm_Addr = 10'd90;
               e.pc = 10'd6; e.cnt = 5'd0;
            end
         endcase
         sb.push_back(e);
         tick();
         got = obs();
         want = sb.pop_front();
         total++;
         if (got !== want) begin
            bad++;
            $display("FAIL jal_ret[%0d]: got pc=%0d cnt=%0d ctx=%0d o/u/h=%b%b%b want pc=%0d cnt=%0d ctx=%0d o/u/h=%b%b%b",
                     i, got.pc, got.cnt, got.ctx, got.ovf, got.unf, got.hlt,
                     want.pc, want.cnt, want.ctx, want.ovf, want.unf, want.hlt);
         end
      end
      clr();
   endtask

   // PC starts at 6. Push k stores 7 for k=0 and 100+k otherwise.
   task automatic test_overflow_underflow();
      int k;
      for (int i = 0; i < 34; i++) begin
         clr();
         if (i < 17) begin
            Stack_Enable = 1; Stack_Write = 1;
            Imm_Addr = 10'(100 + i);
            e.pc = 10'(100 + i);
            if (i < 16) e.cnt = 5'(i + 1);
            else e.ovf = 1'b1;
         end else if (i < 33) begin
            k = 32 - i;
            Stack_Enable = 1;
            e.pc = (k == 0) ? 10'd7 : 10'(100 + k);
            e.cnt = 5'(k);
         end else begin
            Stack_Enable = 1;
            e.pc = 10'd8;
            e.unf = 1'b1;
         end
         sb.push_back(e);
         tick();
         got = obs();
         want = sb.pop_front();
         total++;
         if (got !== want) begin
            bad++;
            $display("FAIL stack[%0d]: got pc=%0d cnt=%0d ctx=%0d o/u/h=%b%b%b want pc=%0d cnt=%0d ctx=%0d o/u/h=%b%b%b",
                     i, got.pc, got.cnt, got.ctx, got.ovf, got.unf, got.hlt,
                     want.pc, want.cnt, want.ctx, want.ovf, want.unf, want.hlt);
         end
      end
      clr();
   endtask

   task automatic test_branch_jump_ctx();
      for (int i = 0; i < 6; i++) begin
         clr();
         case (i)
            0: begin Jump_I = 1; Imm_Addr = 10'd10; e.pc = 10'd10; end
            1: begin Branch = 1; Imm_Addr = 10'd3; e.pc = 10'd11; end
            2: begin
               Branch = 1; Branch_Cond = 1; Imm_Addr = 10'd3;
               e.pc = 10'd3;
            end
            3: begin
               Jump_R = 1; Reg_Addr = 10'd77; Imm_Addr = 10'd500;
               e.pc = 10'd77;
            end
            4: begin
               Change_Context = 1; Jump_I = 1;
               Ctx_Addr = 10'd200; Imm_Addr = 10'd555;
               e.pc = 10'd200; e.ctx = 10'd78;
            end
            default: begin
               Jump_R = 1; Jump_I = 1;
               Reg_Addr = 10'd50; Imm_Addr = 10'd60;
               e.pc = 10'd50;
            end
         endcase
         sb.push_back(e);
         tick();
         got = obs();
         want = sb.pop_front();
         total++;
         if (got !== want) begin
            bad++;
            $display("FAIL branch[%0d]: got pc=%0d cnt=%0d ctx=%0d o/u/h=%b%b%b want pc=%0d cnt=%0d ctx=%0d o/u/h=%b%b%b",
                     i, got.pc, got.cnt, got.ctx, got.ovf, got.unf, got.hlt,
                     want.pc, want.cnt, want.ctx, want.ovf, want.unf, want.hlt);
         end
      end
      clr();
   endtask

   task automatic test_halt();
      for (int i = 0; i < 14; i++) begin
         clr();
         if (i == 0) begin
            Jump_I = 1; Imm_Addr = 10'd20; e.pc = 10'd20;
         end else if (i == 1) begin
            Halt = 1; Jump_I = 1; Imm_Addr = 10'd999;
            e.hlt = 1'b1;
         end else if (i < 12) begin
            Jump_I = 1; Imm_Addr = 10'd999;
            Stack_Enable = 1; Stack_Write = 1;
         end else if (i == 12) begin
            Resume = 1; Stall = 1;
         end else begin
            Resume = 1;
            e.pc = 10'd21; e.hlt = 1'b0;
         end
         sb.push_back(e);
         tick();
         got = obs();
         want = sb.pop_front();
         total++;
         if (got !== want) begin
            bad++;
            $display("FAIL halt[%0d]: got pc=%0d cnt=%0d ctx=%0d o/u/h=%b%b%b want pc=%0d cnt=%0d ctx=%0d o/u/h=%b%b%b",
                     i, got.pc, got.cnt, got.ctx, got.ovf, got.unf, got.hlt,
                     want.pc, want.cnt, want.ctx, want.ovf, want.unf, want.hlt);
         end
      end
      clr();
   endtask

   task automatic test_stall_reset();
      for (int i = 0; i < 9; i++) begin
         clr();
         if (i < 3) begin
            Stall = 1; Stack_Enable = 1; Stack_Write = 1;
            Imm_Addr = 10'd300;
            sb.push_back(e);
            tick();
         end else if (i == 3) begin
            Stack_Enable = 1; Stack_Write = 1; Imm_Addr = 10'd300;
            e.pc = 10'd300; e.cnt = 5'd1;
            sb.push_back(e);
            tick();
         end else if (i == 4) begin
            Halt = 1;
            e.hlt = 1'b1;
            sb.push_back(e);
            tick();
         end else if (i == 5) begin
            Stall = 1;
            #2;
            Reset = 1;
            e = '0;
            sb.push_back(e);
            #1;
         end else if (i == 6) begin
            Reset = 1;
            sb.push_back(e);
            tick();
            Reset = 0;
         end else if (i == 7) begin
            e.pc = 10'd1;
            sb.push_back(e);
            tick();
         end else begin
            Stack_Enable = 1;
            e.pc = 10'd2; e.unf = 1'b1;
            sb.push_back(e);
            tick();
         end
         got = obs();
         want = sb.pop_front();
         total++;
         if (got !== want) begin
            bad++;
            $display("FAIL stall_reset[%0d]: got pc=%0d cnt=%0d ctx=%0d o/u/h=%b%b%b want pc=%0d cnt=%0d ctx=%0d o/u/h=%b%b%b",
                     i, got.pc, got.cnt, got.ctx, got.ovf, got.unf, got.hlt,
                     want.pc, want.cnt, want.ctx, want.ovf, want.unf, want.hlt);
         end
      end
      clr();
   endtask

   initial begin
      total = 0;
      bad = 0;
      e = '0;
      test_reset();
      test_increment();
      test_jal_ret();
      test_overflow_underflow();
      test_branch_jump_ctx();
      test_halt();
      test_stall_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
